// File: rtl/go_seq_pkg.sv
// Shared types and default widths for the go/kill/done sequencer.
package go_seq_pkg;

    localparam int TW_DEF = 8;
    localparam int RW_DEF = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        WAIT = 3'd2,
        KILL = 3'd3,
        CLR  = 3'd4
    } state_e;

endpackage

// File: rtl/go_seq_timer.sv
// Loadable watchdog down-counter. A load of zero leaves it parked at zero,
// so it never reaches the expiry value and the watchdog is effectively off.
module go_seq_timer
    import go_seq_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic          expired
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Expiry is flagged on the last allowed wait cycle, not after it.
    assign expired = (cnt_q == TW'(1));

endmodule

// File: rtl/go_sequencer.sv
// Launches go pulses to a downstream go/kill/done chain with watchdog, kill,
// latch clear and bounded retry. Define GO_SEQ_STATS_EN for pass/fail counters.
module go_sequencer
    import go_seq_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] timeout_cyc,
    input  logic [RW-1:0] max_retry,
    input  logic          done_in,
    input  logic          kill_ltchd,
    output logic          go_out,
    output logic          kill_out,
    output logic          kill_clr,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
`ifdef GO_SEQ_STATS_EN
    ,
    output logic [15:0]   pass_cnt,
    output logic [15:0]   fail_cnt
`endif
);

    state_e        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [RW-1:0] max_q, max_d;
    logic          abort_pend_q, abort_pend_d;
    logic          clr_first_q, clr_first_d;
    logic          go_q, go_d;
    logic          kill_q, kill_d;
    logic          clr_q, clr_d;
    logic          busy_q, busy_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          timer_load;
    logic          timer_exp;

    go_seq_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timeout_cyc),
        .dec      (state_q == WAIT),
        .expired  (timer_exp)
    );

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        max_d        = max_q;
        abort_pend_d = abort_pend_q;
        clr_first_d  = 1'b0;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = GO;
                    retry_d      = '0;
                    max_d        = max_retry;
                    abort_pend_d = 1'b0;
                end
            end
            GO: begin
                timer_load = 1'b1;
                if (abort)
                    abort_pend_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_in) begin
                    pass_d  = 1'b1;
                    state_d = IDLE;
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = KILL;
                end else if (timer_exp) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (abort)
                    abort_pend_d = 1'b1;
                clr_first_d = 1'b1;
                state_d     = CLR;
            end
            CLR: begin
                if (abort)
                    abort_pend_d = 1'b1;
                // The latch status seen in the first clear cycle predates the clear.
                if (!clr_first_q && !kill_ltchd) begin
                    if (abort_pend_q || abort || retry_q == max_q) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = GO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        go_d   = (state_d == GO);
        kill_d = (state_d == KILL);
        clr_d  = (state_d == CLR);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            max_q        <= '0;
            abort_pend_q <= 1'b0;
            clr_first_q  <= 1'b0;
            go_q         <= 1'b0;
            kill_q       <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            max_q        <= max_d;
            abort_pend_q <= abort_pend_d;
            clr_first_q  <= clr_first_d;
            go_q         <= go_d;
            kill_q       <= kill_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    assign go_out    = go_q;
    assign kill_out  = kill_q;
    assign kill_clr  = clr_q;
    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef GO_SEQ_STATS_EN
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    // Counters step in the same cycle the pulse appears and stick at all-ones.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d && pass_cnt_q != 16'hFFFF)
            pass_cnt_d = pass_cnt_q + 16'd1;
        if (fail_d && fail_cnt_q != 16'hFFFF)
            fail_cnt_d = fail_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: doc/go_sequencer.md
GO_SEQUENCER -- requirements
Module: go_sequencer

Interface
REQ-001 SHALL have parameter TW, default 8, timeout counter width.
REQ-002 SHALL have parameter RW, default 2, retry counter width.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request to launch one go sequence.
REQ-006 SHALL have port abort  in  1  request to terminate current sequence.
REQ-007 SHALL have port timeout_cyc  in  TW  watchdog cycles; 0 = watchdog disabled.
REQ-008 SHALL have port max_retry  in  RW  retries allowed after first attempt.
REQ-009 SHALL have port done_in  in  1  completion pulse from the downstream go/kill/done chain.
REQ-010 SHALL have port kill_ltchd  in  1  downstream latched-kill status.
REQ-011 SHALL have port go_out  out  1  one-cycle go pulse to the downstream chain.
REQ-012 SHALL have port kill_out  out  1  one-cycle kill pulse to the downstream chain.
REQ-013 SHALL have port kill_clr  out  1  clear request for the downstream kill latch.
REQ-014 SHALL have ports busy, pass, fail  out  1 each: busy level, pass and fail one-cycle pulses.
REQ-015 SHALL have port retry_cnt  out  RW  retries consumed in the current or last sequence.

Function
REQ-016 SHALL implement states IDLE, GO, WAIT, KILL, CLR; all outputs registered, decoded from state and flags.
REQ-017 IDLE: busy=0; start=1 SHALL go to GO next cycle, clear retry_cnt, sample max_retry, clear abort_pend.
REQ-018 GO: go_out=1 for exactly one cycle; timer loaded with timeout_cyc; next state WAIT.
REQ-019 WAIT: done_in=1 SHALL give pass=1 for one cycle and go to IDLE, with priority over abort and expiry in the same cycle.
REQ-020 WAIT: timer decrements each cycle; at timer==1 with no done_in, SHALL go to KILL; WAIT lasts at most timeout_cyc cycles.
REQ-021 timeout_cyc==0 sampled at GO: no expiry; WAIT exits only on done_in or abort.
REQ-022 abort=1 in GO or WAIT SHALL set abort_pend; in WAIT without done_in, SHALL go to KILL next cycle.
REQ-023 abort in KILL or CLR SHALL set abort_pend; abort in IDLE SHALL be ignored.
REQ-024 KILL: kill_out=1 for exactly one cycle; next state CLR.
REQ-025 CLR: kill_clr=1 every CLR cycle; minimum one cycle; exit on first cycle sampling kill_ltchd=0 after the first.
REQ-026 CLR exit SHALL retry or fail: if abort_pend or retry_cnt==max_retry, fail=1 for one cycle and go to IDLE; otherwise retry_cnt+1 and go to GO.
REQ-027 start while busy=1 SHALL be ignored, not queued.
REQ-028 done_in outside WAIT SHALL be ignored.
REQ-029 busy=1 in every state except IDLE; pass and fail SHALL never assert together.

Reset
REQ-030 reset SHALL force IDLE, timer=0, retry_cnt=0, abort_pend=0, and all outputs 0, including mid-sequence.
REQ-031 The first edge after reset deassertion SHALL behave as IDLE.

Configuration
REQ-032 With GO_SEQ_STATS_EN defined, SHALL add outputs pass_cnt and fail_cnt, 16 bits each, saturating at 0xFFFF.
REQ-033 GO_SEQ_STATS_EN counters SHALL increment on the pass and fail pulses and clear only on reset.
REQ-034 Without GO_SEQ_STATS_EN, the counter ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 Package go_seq_pkg SHALL hold the state enum and default widths TW_DEF=8, RW_DEF=2.
REQ-036 Sub-module go_seq_timer SHALL be used: loadable TW-bit down-counter with expiry flag and disable-on-zero.

Verification
REQ-037 The bench SHALL cover the following scenarios:
- timeout_cyc=5, start at cycle 0, done_in at cycle 3 -> go_out at cycle 1, pass at cycle 4, no kill_out.
- timeout_cyc=3, max_retry=1, no done_in -> two go_out pulses, two kill_out pulses, fail once, retry_cnt=1.
- timeout_cyc=4, done_in and expiry in the same cycle -> pass, no kill_out.
- abort during WAIT with max_retry=3 -> kill_out next cycle, CLR, fail, no retry.
- timeout_cyc=0, done_in after 300 cycles -> pass, no kill_out; reset mid-WAIT -> all outputs 0, IDLE.
- start held high across a sequence -> new go_out only after return to IDLE.
